// File: rtl/count_seq_ctrl.sv
// count_seq_ctrl: sequences x_inc for xl cycles, y_inc for yl cycles, then one clr/done cycle
// Ports:
//   _i_clk            clock, all state updates on posedge
//   _i_rst            synchronous active-high reset
//   _i_start          run request, accepted when start && ready
//   _i_x_lim/_i_y_lim per-run phase lengths, latched on accept
//   _i_hold           (COUNT_SEQ_CTRL_HOLD_EN only) freezes PHASE_X/PHASE_Y
//   __output          {ready, x_inc, y_inc, clr, done}
// Build option: define COUNT_SEQ_CTRL_HOLD_EN to add the hold input.
module count_seq_ctrl #(
    parameter int W = 8
) (
    input  logic         _i_clk,
    input  logic         _i_rst,
    input  logic         _i_start,
    input  logic [W-1:0] _i_x_lim,
    input  logic [W-1:0] _i_y_lim,
`ifdef COUNT_SEQ_CTRL_HOLD_EN
    input  logic         _i_hold,
`endif
    output logic [4:0]   __output
);
    typedef enum logic [1:0] {IDLE, PHASE_X, PHASE_Y, FIN} state_t;
    state_t state, state_n;
    logic [W-1:0] cnt, cnt_n, xl, xl_n, yl, yl_n;
    logic frz;
`ifdef COUNT_SEQ_CTRL_HOLD_EN
    // hold is registered so outputs stay a pure decode of flops
    logic hold_q;
    always_ff @(posedge _i_clk)
        hold_q <= _i_rst ? 1'b0 : _i_hold;
    assign frz = hold_q;
`else
    assign frz = 1'b0;
`endif
    always_ff @(posedge _i_clk) begin
        if (_i_rst) begin
            state <= IDLE;
            cnt   <= '0;
            xl    <= '0;
            yl    <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            xl    <= xl_n;
            yl    <= yl_n;
        end
    end
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        xl_n    = xl;
        yl_n    = yl;
        case (state)
            IDLE: if (_i_start) begin
                xl_n    = _i_x_lim;
                yl_n    = _i_y_lim;
                cnt_n   = '0;
                state_n = (_i_x_lim != '0) ? PHASE_X : (_i_y_lim != '0) ? PHASE_Y : FIN;
            end
            PHASE_X: if (!frz) begin
                cnt_n   = (cnt == xl - 1'b1) ? '0 : cnt + 1'b1;
                state_n = (cnt != xl - 1'b1) ? PHASE_X : (yl != '0) ? PHASE_Y : FIN;
            end
            PHASE_Y: if (!frz) begin
                cnt_n   = (cnt == yl - 1'b1) ? '0 : cnt + 1'b1;
                state_n = (cnt == yl - 1'b1) ? FIN : PHASE_Y;
            end
            default: state_n = IDLE;
        endcase
    end
    assign __output = {state == IDLE,
                       state == PHASE_X && !frz,
                       state == PHASE_Y && !frz,
                       state == FIN,
                       state == FIN};
endmodule

// File: tb/tb_count_seq_ctrl.sv
// tb_count_seq_ctrl: directed self-checking bench for count_seq_ctrl
module tb_count_seq_ctrl;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [7:0] x_lim = 8'd0;
    logic [7:0] y_lim = 8'd0;
    logic       hold = 1'b0;
    logic [4:0] out;
    int         errs = 0;
    int         n = 0;

    localparam logic [4:0] I = 5'b10000, X = 5'b01000, Y = 5'b00100, F = 5'b00011;

    count_seq_ctrl #(.W(8)) dut (
        ._i_clk(clk),
        ._i_rst(rst),
        ._i_start(start),
        ._i_x_lim(x_lim),
        ._i_y_lim(y_lim),
`ifdef COUNT_SEQ_CTRL_HOLD_EN
        ._i_hold(hold),
`endif
        .__output(out)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [4:0] got, input logic [4:0] exp);
        n++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s got=%b exp=%b", tag, got, exp);
        end
    endtask

    // accept in the current cycle N, then check cycles N+1 .. N+xl+yl+2
    task automatic run(input int xl, input int yl, input string tag);
        logic [4:0] e;
        x_lim = 8'(xl);
        y_lim = 8'(yl);
        start = 1'b1;
        check({tag, "_pre"}, out, I);
        step();
        start = 1'b0;
        for (int c = 1; c <= xl + yl + 2; c++) begin
            e = (c <= xl) ? X : (c <= xl + yl) ? Y : (c == xl + yl + 1) ? F : I;
            check($sformatf("%s_c%0d", tag, c), out, e);
            step();
        end
    endtask

    initial begin
        logic [4:0] e;
        step();
        step();
        check("reset", out, I);
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            step();
            check("idle", out, I);
        end
        run(8, 6, "nominal");
        run(0, 3, "x0y3");
        run(0, 0, "x0y0");
        run(1, 1, "x1y1");
        // start held high, limits changed mid-run: 2/1 run then 5/5 run
        x_lim = 8'd2;
        y_lim = 8'd1;
        start = 1'b1;
        step();
        x_lim = 8'd5;
        y_lim = 8'd5;
        for (int c = 1; c <= 17; c++) begin
            e = (c <= 2) ? X : (c == 3) ? Y : (c == 4) ? F : (c == 5) ? I :
                (c <= 10) ? X : (c <= 15) ? Y : (c == 16) ? F : I;
            check($sformatf("busy_c%0d", c), out, e);
            if (c == 6) start = 1'b0;
            step();
        end
        // reset asserted in cycle N+10 of an 8/6 run
        x_lim = 8'd8;
        y_lim = 8'd6;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            check($sformatf("rstmid_c%0d", c), out, (c <= 8) ? X : Y);
            if (c < 10) step();
        end
        rst = 1'b1;
        step();
        check("rstmid_idle", out, I);
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            step();
            check("rstmid_nodone", out, I);
        end
        run(8, 6, "after_rst");
`ifdef COUNT_SEQ_CTRL_HOLD_EN
        // hold sampled high at the ends of N+1..N+3 freezes N+2..N+4
        x_lim = 8'd4;
        y_lim = 8'd2;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int c = 1; c <= 11; c++) begin
            hold = (c >= 1 && c <= 3);
            e = (c == 1 || (c >= 5 && c <= 7)) ? X : (c >= 2 && c <= 4) ? 5'b00000 :
                (c <= 9) ? Y : (c == 10) ? F : I;
            check($sformatf("hold_c%0d", c), out, e);
            step();
        end
        hold = 1'b0;
`endif
        $display("Result: errors=%0d of %0d checks", errs, n);
        $finish;
    end
endmodule
